uart_tx_frame_sequencer: RTL and testbench

Parametrised UART transmit-side sequencer between the register file / ALU result paths and the UART transmitter. Queues pending responses (1-word register reads, RESULT_BYTES-word ALU results) in a small FIFO and serialises each one byte-by-byte. Each byte is handed off using the transmitter busy handshake. Gates the UART receiver controller while any response is pending or in flight.

---
 rtl/uart_tx_frame_sequencer.sv | 141 ++++++++++++++
 tb/tb_uart_tx_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit sequencer: queues register-read / ALU-result messages and hands them
// to the transmitter byte-by-byte, LSB first. Optional length header: UART_TX_SEQ_LEN_HEADER_EN.
module uart_tx_frame_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_BYTES = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             read_data_valid,
  input  logic [DATA_WIDTH-1:0]            read_data,
  input  logic                             alu_result_valid,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0] alu_result,
  input  logic                             transmitter_busy_sync,
  output logic                             transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]            transmitter_parallel_data,
  output logic                             uart_receiver_controller_en,
  output logic                             queue_full,
  output logic                             drop
);

  localparam int PAYLOAD_W = RESULT_BYTES * DATA_WIDTH;
  localparam int LEN_W     = 4;
`ifdef UART_TX_SEQ_LEN_HEADER_EN
  localparam int SHIFT_W   = PAYLOAD_W + DATA_WIDTH;
`else
  localparam int SHIFT_W   = PAYLOAD_W;
`endif
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, ACTIVE, GAP} state_t;
  state_t state, state_next;

  logic [LEN_W-1:0]     len_mem     [QUEUE_DEPTH];
  logic [PAYLOAD_W-1:0] payload_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [SHIFT_W-1:0]   shift;
  logic [LEN_W-1:0]     byte_cnt;
  logic                 any_valid, push, pop, empty;
  logic [LEN_W-1:0]     push_len;
  logic [PAYLOAD_W-1:0] push_payload;

  assign any_valid  = read_data_valid | alu_result_valid;
  assign queue_full = (count == CNT_W'(QUEUE_DEPTH));
  assign empty      = (count == '0);
  // A full queue rejects the push even when the head is popped in the same cycle.
  assign push       = any_valid & ~queue_full;
  assign pop        = (state == IDLE) & ~empty & ~transmitter_busy_sync;

  always_comb begin
    if (read_data_valid) begin
      push_len     = LEN_W'(1);
      push_payload = PAYLOAD_W'(read_data);
    end else begin
      push_len     = LEN_W'(RESULT_BYTES);
      push_payload = alu_result;
    end
  end

  // NOTE: queue storage is deliberately not reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      len_mem[wr_ptr]     <= push_len;
      payload_mem[wr_ptr] <= push_payload;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift    <= '0;
      byte_cnt <= '0;
    end else if (pop) begin
`ifdef UART_TX_SEQ_LEN_HEADER_EN
      // Header byte sits in the low lane so it leaves first; byte_cnt covers header + payload.
      shift    <= {payload_mem[rd_ptr], DATA_WIDTH'(len_mem[rd_ptr])};
      byte_cnt <= len_mem[rd_ptr];
`else
      shift    <= payload_mem[rd_ptr];
      byte_cnt <= len_mem[rd_ptr] - LEN_W'(1);
`endif
    end else if (state == GAP) begin
      shift    <= shift >> DATA_WIDTH;
      byte_cnt <= byte_cnt - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_next                      = state;
    transmitter_parallel_data_valid = 1'b0;
    case (state)
      IDLE:   if (pop) state_next = SEND;
      SEND: begin
        transmitter_parallel_data_valid = 1'b1;
        if (transmitter_busy_sync) state_next = ACTIVE;
      end
      ACTIVE: begin
        transmitter_parallel_data_valid = 1'b1;
        if (!transmitter_busy_sync) state_next = (byte_cnt != '0) ? GAP : IDLE;
      end
      GAP:     state_next = SEND;
      default: state_next = IDLE;
    endcase
    transmitter_parallel_data = transmitter_parallel_data_valid ? shift[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop                        <= 1'b0;
      uart_receiver_controller_en <= 1'b1;
    end else begin
      drop                        <= (read_data_valid & alu_result_valid) | (any_valid & queue_full);
      uart_receiver_controller_en <= (state == IDLE) & empty & ~push;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Directed bench for uart_tx_frame_sequencer; follows UART_TX_SEQ_LEN_HEADER_EN if defined.
module tb_uart_tx_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_data_valid;
  logic [7:0]  read_data;
  logic        alu_result_valid;
  logic [15:0] alu_result;
  logic        transmitter_busy_sync;
  logic        transmitter_parallel_data_valid;
  logic [7:0]  transmitter_parallel_data;
  logic        uart_receiver_controller_en;
  logic        queue_full;
  logic        drop;

  int total = 0;
  int bad   = 0;

  uart_tx_frame_sequencer #(.DATA_WIDTH(8), .RESULT_BYTES(2), .QUEUE_DEPTH(4)) dut (
    .clk                             (clk),
    .reset_n                         (reset_n),
    .read_data_valid                 (read_data_valid),
    .read_data                       (read_data),
    .alu_result_valid                (alu_result_valid),
    .alu_result                      (alu_result),
    .transmitter_busy_sync           (transmitter_busy_sync),
    .transmitter_parallel_data_valid (transmitter_parallel_data_valid),
    .transmitter_parallel_data       (transmitter_parallel_data),
    .uart_receiver_controller_en     (uart_receiver_controller_en),
    .queue_full                      (queue_full),
    .drop                            (drop)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer_byte(input logic [7:0] exp, input int max_wait, input string name);
    int n = 0;
    while (transmitter_parallel_data_valid !== 1'b1 && n < max_wait) begin
      tick();
      n++;
    end
    total++;
    if (transmitter_parallel_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: valid=%b after %0d cycles, required 1", name,
               transmitter_parallel_data_valid, n);
      return;
    end
    total++;
    if (transmitter_parallel_data !== exp) begin
      bad++;
      $display("FAIL %s: data=%h required %h", name, transmitter_parallel_data, exp);
    end
    transmitter_busy_sync = 1'b1;
    repeat (3) tick();
    total++;
    if (transmitter_parallel_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s hold: valid=%b during busy, required 1", name,
               transmitter_parallel_data_valid);
    end
    transmitter_busy_sync = 1'b0;
    tick();
    total++;
    if (transmitter_parallel_data_valid !== 1'b0 || transmitter_parallel_data !== 8'h00) begin
      bad++;
      $display("FAIL %s release: valid=%b data=%h, required 0/00", name,
               transmitter_parallel_data_valid, transmitter_parallel_data);
    end
  endtask

  task automatic xfer_msg(input logic [7:0] b0, input logic [7:0] b1, input int len,
                          input int first_wait, input string name);
    logic [7:0] seq [3];
    int cnt = 0;
`ifdef UART_TX_SEQ_LEN_HEADER_EN
    seq[cnt] = 8'(len);
    cnt++;
`endif
    seq[cnt] = b0;
    cnt++;
    if (len > 1) begin
      seq[cnt] = b1;
      cnt++;
    end
    for (int i = 0; i < cnt; i++) xfer_byte(seq[i], (i == 0) ? first_wait : 1, name);
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      tick();
      total++;
      if (transmitter_parallel_data_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s: valid=%b data=%h in quiet cycle %0d, required 0", name,
                 transmitter_parallel_data_valid, transmitter_parallel_data, i);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (transmitter_parallel_data_valid !== 1'b0 || transmitter_parallel_data !== 8'h00 ||
        queue_full !== 1'b0 || drop !== 1'b0 || uart_receiver_controller_en !== 1'b1) begin
      bad++;
      $display("FAIL %s: valid=%b data=%h full=%b drop=%b rx_en=%b, required 0 00 0 0 1", name,
               transmitter_parallel_data_valid, transmitter_parallel_data, queue_full, drop,
               uart_receiver_controller_en);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset_state");
    reset_n = 1'b1;
    tick();
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_read_path();
    read_data_valid = 1'b1;
    read_data       = 8'hA5;
    tick();
    read_data_valid = 1'b0;
    total++;
    if (transmitter_parallel_data_valid !== 1'b0 || uart_receiver_controller_en !== 1'b0) begin
      bad++;
      $display("FAIL read_enqueue: valid=%b rx_en=%b, required 0/0",
               transmitter_parallel_data_valid, uart_receiver_controller_en);
    end
    xfer_msg(8'hA5, 8'h00, 1, 1, "read_byte");
    total++;
    if (uart_receiver_controller_en !== 1'b0) begin
      bad++;
      $display("FAIL read_rx_en_idle0: rx_en=%b required 0", uart_receiver_controller_en);
    end
    tick();
    total++;
    if (uart_receiver_controller_en !== 1'b1) begin
      bad++;
      $display("FAIL read_rx_en_back: rx_en=%b required 1", uart_receiver_controller_en);
    end
  endtask

  task automatic test_alu_path();
    alu_result_valid = 1'b1;
    alu_result       = 16'h1234;
    tick();
    alu_result_valid = 1'b0;
    xfer_msg(8'h34, 8'h12, 2, 1, "alu_bytes");
    expect_quiet(3, "alu_after");
  endtask

  task automatic test_simultaneous();
    read_data_valid  = 1'b1;
    read_data        = 8'h11;
    alu_result_valid = 1'b1;
    alu_result       = 16'hBEEF;
    tick();
    read_data_valid  = 1'b0;
    alu_result_valid = 1'b0;
    total++;
    if (drop !== 1'b1) begin
      bad++;
      $display("FAIL simul_drop: drop=%b required 1", drop);
    end
    tick();
    total++;
    if (drop !== 1'b0) begin
      bad++;
      $display("FAIL simul_drop_pulse: drop=%b required 0", drop);
    end
    xfer_msg(8'h11, 8'h00, 1, 0, "simul_read");
    expect_quiet(5, "simul_no_alu");
  endtask

  task automatic test_full_queue();
    transmitter_busy_sync = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      read_data_valid = 1'b1;
      read_data       = 8'(i);
      tick();
      total++;
      if (queue_full !== (i >= 4) || drop !== (i == 5)) begin
        bad++;
        $display("FAIL full_push%0d: full=%b drop=%b, required %b %b", i, queue_full, drop,
                 (i >= 4), (i == 5));
      end
    end
    read_data_valid       = 1'b0;
    transmitter_busy_sync = 1'b0;
    for (int i = 1; i <= 4; i++) xfer_msg(8'(i), 8'h00, 1, 2, "full_drain");
    expect_quiet(4, "full_no_fifth");
    total++;
    if (queue_full !== 1'b0) begin
      bad++;
      $display("FAIL full_drained: full=%b required 0", queue_full);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      read_data_valid = 1'b1;
      read_data       = 8'h21 + 8'(i);
      tick();
    end
    read_data_valid       = 1'b0;
    transmitter_busy_sync = 1'b1;
    total++;
    if (transmitter_parallel_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_send: valid=%b required 1", transmitter_parallel_data_valid);
    end
    tick();
    total++;
    if (transmitter_parallel_data_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_active: valid=%b required 1", transmitter_parallel_data_valid);
    end
    reset_n = 1'b0;
    tick();
    check_idle_outputs("rst_mid_after");
    reset_n               = 1'b1;
    transmitter_busy_sync = 1'b0;
    expect_quiet(6, "rst_mid_nothing");
    check_idle_outputs("rst_mid_final");
  endtask

  task automatic test_busy_at_pop();
    transmitter_busy_sync = 1'b1;
    read_data_valid       = 1'b1;
    read_data             = 8'h5A;
    tick();
    read_data_valid = 1'b0;
    expect_quiet(3, "busy_hold_no_pop");
    transmitter_busy_sync = 1'b0;
    xfer_msg(8'h5A, 8'h00, 1, 1, "busy_late_pop");
  endtask

  initial begin
    reset_n               = 1'b0;
    read_data_valid       = 1'b0;
    read_data             = '0;
    alu_result_valid      = 1'b0;
    alu_result            = '0;
    transmitter_busy_sync = 1'b0;
    #1;
    test_reset();
    test_read_path();
    test_alu_path();
    test_simultaneous();
    test_full_queue();
    test_reset_mid();
    test_busy_at_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
